// File: rtl/control_unit_mdu_if.sv
// Decode-stage bundle between the pipeline D stage and control_unit_mdu.
// The slave side is the control unit; the master side is the pipeline/bench.
interface control_unit_mdu_if #(
  parameter int unsigned ALU_CTRL_W = 3
);
  logic [5:0]            i_Op;
  logic [5:0]            i_funct;
  logic                  i_InstrValidD;
  logic                  i_StallD;
  logic                  o_RegWriteD;
  logic                  o_MemtoRegD;
  logic                  o_MemWriteD;
  logic [ALU_CTRL_W-1:0] o_ALUControlD;
  logic                  o_ALUSrcD;
  logic                  o_RegDstD;
  logic                  o_BranchD;
  logic                  o_BranchNeD;
  logic                  o_JumpD;
  logic                  o_LoadD;
  logic                  o_MdStartD;
  logic [1:0]            o_MdOpD;
  logic                  o_MfhiD;
  logic                  o_MfloD;
  logic                  o_IllegalD;
  logic                  o_MdBusy;
  logic                  o_MdDone;
  logic                  o_MdStallD;

  modport slave (
    input  i_Op, i_funct, i_InstrValidD, i_StallD,
    output o_RegWriteD, o_MemtoRegD, o_MemWriteD, o_ALUControlD, o_ALUSrcD,
           o_RegDstD, o_BranchD, o_BranchNeD, o_JumpD, o_LoadD, o_MdStartD,
           o_MdOpD, o_MfhiD, o_MfloD, o_IllegalD, o_MdBusy, o_MdDone, o_MdStallD
  );

  modport master (
    output i_Op, i_funct, i_InstrValidD, i_StallD,
    input  o_RegWriteD, o_MemtoRegD, o_MemWriteD, o_ALUControlD, o_ALUSrcD,
           o_RegDstD, o_BranchD, o_BranchNeD, o_JumpD, o_LoadD, o_MdStartD,
           o_MdOpD, o_MfhiD, o_MfloD, o_IllegalD, o_MdBusy, o_MdDone, o_MdStallD
  );
endinterface

// File: rtl/control_unit_mdu.sv
// MIPS D-stage control decode with a multi-cycle multiply/divide sequencer
// that tracks the in-flight MDU op and stalls dependent instructions.
module control_unit_mdu #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input logic               i_CLK,
  input logic               i_RST,
  control_unit_mdu_if.slave bus
);
  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;

  logic       reg_write, mem_to_reg, mem_write, alu_src, reg_dst;
  logic       branch, branch_ne, jump, load, md_op, mfhi, mflo, legal;
  logic [2:0] alu;
  logic [1:0] md_sel;

  always_comb begin
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    jump       = 1'b0;
    load       = 1'b0;
    md_op      = 1'b0;
    mfhi       = 1'b0;
    mflo       = 1'b0;
    legal      = 1'b1;
    alu        = ALU_ADD;
    md_sel     = 2'b00;
    case (bus.i_Op)
      6'b000000: begin
        case (bus.i_funct)
          6'b100000: begin reg_write = 1'b1; reg_dst = 1'b1; alu = ALU_ADD; end
          6'b100010: begin reg_write = 1'b1; reg_dst = 1'b1; alu = ALU_SUB; end
          6'b100100: begin reg_write = 1'b1; reg_dst = 1'b1; alu = ALU_AND; end
          6'b100101: begin reg_write = 1'b1; reg_dst = 1'b1; alu = ALU_OR;  end
          6'b101010: begin reg_write = 1'b1; reg_dst = 1'b1; alu = ALU_SLT; end
          6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
            md_op  = 1'b1;
            md_sel = bus.i_funct[1:0];
          end
          6'b010000: begin reg_write = 1'b1; reg_dst = 1'b1; mfhi = 1'b1; end
          6'b010010: begin reg_write = 1'b1; reg_dst = 1'b1; mflo = 1'b1; end
          default:   legal = 1'b0;
        endcase
      end
      6'b100011: begin reg_write = 1'b1; mem_to_reg = 1'b1; alu_src = 1'b1; load = 1'b1; end
      6'b101011: begin mem_write = 1'b1; alu_src = 1'b1; end
      6'b000100: begin branch = 1'b1; alu = ALU_SUB; end
      6'b000101: begin branch_ne = 1'b1; alu = ALU_SUB; end
      6'b001000: begin reg_write = 1'b1; alu_src = 1'b1; end
      6'b000010: jump = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  logic valid, busy, done, md_stall, start;
  logic [CNT_W-1:0] load_cnt;

  assign valid    = bus.i_InstrValidD;
  assign busy     = (state == S_BUSY);
  assign done     = busy && (cnt == '0);
  // The done cycle still counts as busy so HI/LO readers wait for the write.
  assign md_stall = valid && (md_op || mfhi || mflo) && busy;
  assign start    = valid && md_op && !busy && !bus.i_StallD;
  assign load_cnt = md_sel[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_BUSY;
            cnt   <= load_cnt;
          end
        end
        default: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    bus.o_ALUControlD      = '0;
    bus.o_ALUControlD[2:0] = alu;
  end

  assign bus.o_RegWriteD = valid && reg_write && !md_stall;
  assign bus.o_MemtoRegD = valid && mem_to_reg;
  assign bus.o_MemWriteD = valid && mem_write && !md_stall;
  assign bus.o_ALUSrcD   = valid && alu_src;
  assign bus.o_RegDstD   = valid && reg_dst;
  assign bus.o_BranchD   = valid && branch && !md_stall;
  assign bus.o_BranchNeD = valid && branch_ne && !md_stall;
  assign bus.o_JumpD     = valid && jump && !md_stall;
  assign bus.o_LoadD     = valid && load;
  assign bus.o_MdStartD  = start;
  assign bus.o_MdOpD     = md_sel;
  assign bus.o_MfhiD     = valid && mfhi;
  assign bus.o_MfloD     = valid && mflo;
  assign bus.o_IllegalD  = valid && !legal;
  assign bus.o_MdBusy    = busy;
  assign bus.o_MdDone    = done;
  assign bus.o_MdStallD  = md_stall;
endmodule
